// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 bus stage: timing defaults, FSM encoding and the
// HD44780 command codes that the sequencers also use.
package lcd1602_pkg;

  localparam int unsigned T_POWERUP_DEF = 750000;
  localparam int unsigned T_SETUP_DEF   = 4;
  localparam int unsigned T_EN_HIGH_DEF = 25;
  localparam int unsigned T_HOLD_DEF    = 2;
  localparam int unsigned T_CMD_DEF     = 2500;
  localparam int unsigned T_CLR_DEF     = 82000;

  localparam logic [7:0] CLEAR_DISPLAY = 8'h01;
  localparam logic [7:0] RETURN_HOME   = 8'h02;

  typedef enum logic [2:0] {
    StPowerup,
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StExec
  } state_e;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // 0x03 decodes as return-home on the HD44780 (bit 0 is don't-care).
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CLEAR_DISPLAY || data == RETURN_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd1602_bus_timing_if.sv
// Upstream byte handshake plus the HD44780 pin bundle driven by the bus stage.
interface lcd1602_bus_timing_if;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, busy, lcd_rs, lcd_rw, lcd_en, lcd_data
  );

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, busy, lcd_rs, lcd_rw, lcd_en, lcd_data
  );
endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter shared by every timed state; holds at zero until reloaded.
module lcd_delay_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd1602_bus_timing.sv
// HD44780 write-bus stage: accepts one byte per handshake and sequences rs/data/en with
// setup, pulse-width, hold and execution timing from a single shared delay counter.
module lcd1602_bus_timing
  import lcd1602_pkg::*;
#(
  parameter int unsigned T_POWERUP_CYC = T_POWERUP_DEF,
  parameter int unsigned T_SETUP_CYC   = T_SETUP_DEF,
  parameter int unsigned T_EN_HIGH_CYC = T_EN_HIGH_DEF,
  parameter int unsigned T_HOLD_CYC    = T_HOLD_DEF,
  parameter int unsigned T_CMD_CYC     = T_CMD_DEF,
  parameter int unsigned T_CLR_CYC     = T_CLR_DEF
) (
  input logic                  clk,
  input logic                  reset,
  lcd1602_bus_timing_if.slave  bus
);

  localparam int unsigned MaxCyc = max_of(max_of(max_of(T_POWERUP_CYC, T_SETUP_CYC),
                                                 max_of(T_EN_HIGH_CYC, T_HOLD_CYC)),
                                          max_of(T_CMD_CYC, T_CLR_CYC));
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  state_e          state_q;
  logic            in_ready_q;
  logic            busy_q;
  logic            lcd_en_q;
  logic            lcd_rs_q;
  logic [7:0]      lcd_data_q;

  logic            cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_zero;

  lcd_delay_counter #(
    .Width (CntW)
  ) u_delay (
    .clk     (clk),
    .load_i  (cnt_load),
    .value_i (cnt_load_val),
    .zero_o  (cnt_zero)
  );

  // Counter reloads N-1 on the same edge that enters the next timed state.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (reset) begin
      cnt_load     = 1'b1;
      cnt_load_val = CntW'(T_POWERUP_CYC - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            cnt_load     = 1'b1;
            cnt_load_val = CntW'(T_SETUP_CYC - 1);
          end
        end
        StSetup: begin
          if (cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = CntW'(T_EN_HIGH_CYC - 1);
          end
        end
        StPulse: begin
          if (cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = CntW'(T_HOLD_CYC - 1);
          end
        end
        StHold: begin
          if (cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = is_slow_cmd(lcd_rs_q, lcd_data_q) ? CntW'(T_CLR_CYC - 1)
                                                             : CntW'(T_CMD_CYC - 1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StPowerup;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
    end else begin
      unique case (state_q)
        StPowerup: begin
          if (cnt_zero) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        StIdle: begin
          if (bus.in_valid) begin
            state_q    <= StSetup;
            lcd_rs_q   <= bus.in_rs;
            lcd_data_q <= bus.in_data;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StSetup: begin
          if (cnt_zero) begin
            state_q  <= StPulse;
            lcd_en_q <= 1'b1;
          end
        end
        StPulse: begin
          if (cnt_zero) begin
            state_q  <= StHold;
            lcd_en_q <= 1'b0;
          end
        end
        StHold: begin
          if (cnt_zero) begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_zero) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= StPowerup;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          lcd_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.lcd_en   = lcd_en_q;
  assign bus.lcd_rs   = lcd_rs_q;
  assign bus.lcd_data = lcd_data_q;
  assign bus.lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd1602_bus_timing.sv
// Directed bench for lcd1602_bus_timing with short simulation timing parameters.
module tb_lcd1602_bus_timing;

  logic clk;
  logic reset;

  lcd1602_bus_timing_if bus ();

  lcd1602_bus_timing #(
    .T_POWERUP_CYC (10),
    .T_SETUP_CYC   (2),
    .T_EN_HIGH_CYC (3),
    .T_HOLD_CYC    (1),
    .T_CMD_CYC     (5),
    .T_CLR_CYC     (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec   = 0;
  int n_err   = 0;
  int n_pulse = 0;

  always @(posedge bus.lcd_en) n_pulse++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sample 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic powerup(input string tag);
    repeat (9) tick();
    check({tag, "_rdy_lo"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_en_lo"}, 32'(bus.lcd_en), 32'd0);
    tick();
    check({tag, "_rdy_hi"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
  endtask

  // Returns just after the accept edge k.
  task automatic send(input logic rs, input logic [7:0] data);
    bus.in_valid = 1'b1;
    bus.in_rs    = rs;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // lat = edges from accept until in_ready is seen high before that edge.
  task automatic xfer(input string tag, input logic rs, input logic [7:0] data, input int lat);
    int p0;
    p0 = n_pulse;
    send(rs, data);
    repeat (lat - 2) tick();
    check({tag, "_rdy_lo"}, 32'(bus.in_ready), 32'd0);
    tick();
    check({tag, "_rdy_hi"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_pulses"}, 32'(n_pulse - p0), 32'd1);
  endtask

  initial begin
    int p0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_rs    = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state.
    repeat (3) tick();
    check("rst_rdy", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_en", 32'(bus.lcd_en), 32'd0);
    check("rst_rs", 32'(bus.lcd_rs), 32'd0);
    check("rst_data", 32'(bus.lcd_data), 32'd0);
    check("rst_rw", 32'(bus.lcd_rw), 32'd0);
    reset = 1'b0;
    powerup("pwr");

    // Data write: detailed strobe timing.
    p0 = n_pulse;
    send(1'b1, 8'h41);
    check("d41_rs", 32'(bus.lcd_rs), 32'd1);
    check("d41_data", 32'(bus.lcd_data), 32'h41);
    check("d41_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    check("d41_en_k1", 32'(bus.lcd_en), 32'd0);
    tick();
    check("d41_en_k2", 32'(bus.lcd_en), 32'd1);
    repeat (2) tick();
    check("d41_en_k4", 32'(bus.lcd_en), 32'd1);
    tick();
    check("d41_en_k5", 32'(bus.lcd_en), 32'd0);
    check("d41_data_hold", 32'(bus.lcd_data), 32'h41);
    repeat (5) tick();
    check("d41_rdy_lo", 32'(bus.in_ready), 32'd0);
    tick();
    check("d41_rdy_hi", 32'(bus.in_ready), 32'd1);
    check("d41_pulses", 32'(n_pulse - p0), 32'd1);
    check("d41_idle_data", 32'(bus.lcd_data), 32'h41);

    // Slow vs ordinary commands.
    xfer("clr", 1'b0, 8'h01, 27);
    xfer("home", 1'b0, 8'h02, 27);
    xfer("home3", 1'b0, 8'h03, 27);
    xfer("func", 1'b0, 8'h38, 12);
    xfer("d01", 1'b1, 8'h01, 12);

    // Held in_valid: three bytes, 12-cycle spacing.
    p0 = n_pulse;
    bus.in_valid = 1'b1;
    bus.in_rs    = 1'b1;
    bus.in_data  = 8'hA1;
    tick();
    check("b2b_0_data", 32'(bus.lcd_data), 32'hA1);
    bus.in_data = 8'hA2;
    repeat (11) tick();
    check("b2b_0_wait", 32'(bus.lcd_data), 32'hA1);
    check("b2b_0_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    check("b2b_1_data", 32'(bus.lcd_data), 32'hA2);
    check("b2b_1_rdy", 32'(bus.in_ready), 32'd0);
    bus.in_data = 8'hA3;
    repeat (12) tick();
    check("b2b_2_data", 32'(bus.lcd_data), 32'hA3);
    bus.in_valid = 1'b0;
    repeat (11) tick();
    check("b2b_end_rdy", 32'(bus.in_ready), 32'd1);
    check("b2b_pulses", 32'(n_pulse - p0), 32'd3);

    // New data pulsed during EXEC is ignored.
    p0 = n_pulse;
    send(1'b0, 8'h38);
    repeat (7) tick();
    bus.in_valid = 1'b1;
    bus.in_rs    = 1'b1;
    bus.in_data  = 8'hAA;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    check("ign_rdy_lo", 32'(bus.in_ready), 32'd0);
    tick();
    check("ign_rdy_hi", 32'(bus.in_ready), 32'd1);
    check("ign_data", 32'(bus.lcd_data), 32'h38);
    check("ign_rs", 32'(bus.lcd_rs), 32'd0);
    repeat (3) tick();
    check("ign_pulses", 32'(n_pulse - p0), 32'd1);
    check("ign_still_rdy", 32'(bus.in_ready), 32'd1);

    // Reset mid-PULSE.
    send(1'b1, 8'h55);
    repeat (3) tick();
    check("mid_en_hi", 32'(bus.lcd_en), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_en_lo", 32'(bus.lcd_en), 32'd0);
    check("mid_data", 32'(bus.lcd_data), 32'd0);
    check("mid_rs", 32'(bus.lcd_rs), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd1);
    tick();
    reset = 1'b0;
    powerup("pwr2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
